// File: rtl/snn_run_sequencer.sv
// Run sequencer: per sample pulses network reset, gates spikes, counts outputs, streams counts and reports the argmax.
// Latency 2+T*P+N cycles per sample plus one done cycle; no backpressure, abort cancels any non-idle state.
module snn_run_sequencer #(
   parameter int NUM_OUTPUTS   = 10,
   parameter int OUT_ADDR_BITS = 4,
   parameter int COUNT_WIDTH   = 32,
   parameter int TIMESTEP_BITS = 8,
   parameter int SAMPLE_BITS   = 4,
   parameter int PERIOD_BITS   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 abort,
   input  logic [TIMESTEP_BITS-1:0]             cfg_sim_time,
   input  logic [SAMPLE_BITS-1:0]               cfg_num_samples,
   input  logic [PERIOD_BITS-1:0]               cfg_spike_period,
   input  logic [1:0]                           cfg_mode,
   input  logic [COUNT_WIDTH-1:0]               cfg_stop_count,
   input  logic [NUM_OUTPUTS-1:0]               spike_out,
   output logic                                 network_rst,
   output logic                                 spike_en,
   output logic [TIMESTEP_BITS-1:0]             timestep,
   output logic [SAMPLE_BITS-1:0]               sample_idx,
   output logic                                 res_wen,
   output logic [SAMPLE_BITS+OUT_ADDR_BITS-1:0] res_addr,
   output logic [COUNT_WIDTH-1:0]               res_data,
   output logic [OUT_ADDR_BITS-1:0]             winner,
   output logic [COUNT_WIDTH-1:0]               winner_count,
   output logic                                 winner_valid,
   output logic [TIMESTEP_BITS-1:0]             stop_timestep,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 aborted
);
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_NET_RST    = 3'd1;
   localparam logic [2:0] S_RUN        = 3'd2;
   localparam logic [2:0] S_WRITE      = 3'd3;
   localparam logic [2:0] S_SAMPLE_END = 3'd4;
   localparam logic [2:0] S_DONE       = 3'd5;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   logic [2:0]               state_q, state_d;
   logic [TIMESTEP_BITS-1:0] sim_time_q, sim_time_d;
   logic [SAMPLE_BITS-1:0]   num_samples_q, num_samples_d;
   logic [PERIOD_BITS-1:0]   period_q, period_d;
   logic                     thresh_mode_q, thresh_mode_d;
   logic [COUNT_WIDTH-1:0]   stop_count_q, stop_count_d;
   logic [TIMESTEP_BITS-1:0] timestep_q, timestep_d;
   logic [PERIOD_BITS-1:0]   phase_q, phase_d;
   logic [SAMPLE_BITS-1:0]   sample_idx_q, sample_idx_d;
   logic [OUT_ADDR_BITS-1:0] wr_idx_q, wr_idx_d;
   logic [COUNT_WIDTH-1:0]   cnt_q [NUM_OUTPUTS];
   logic [COUNT_WIDTH-1:0]   cnt_d [NUM_OUTPUTS];
   logic [COUNT_WIDTH-1:0]   cnt_inc [NUM_OUTPUTS];
   logic [COUNT_WIDTH-1:0]   max_q, max_d;
   logic [OUT_ADDR_BITS-1:0] max_idx_q, max_idx_d;
   logic [OUT_ADDR_BITS-1:0] winner_q, winner_d;
   logic [COUNT_WIDTH-1:0]   winner_count_q, winner_count_d;
   logic [TIMESTEP_BITS-1:0] stop_timestep_q, stop_timestep_d;
   logic                     aborted_q, aborted_d;

   logic                     thresh_hit;
   logic [COUNT_WIDTH-1:0]   cur_cnt;
   logic [COUNT_WIDTH-1:0]   run_max;
   logic [OUT_ADDR_BITS-1:0] run_idx;
   logic                     phase_wrap;
   logic                     run_last;

   // Saturating increments, threshold detect, and the running max over the write stream.
   always_comb begin
      thresh_hit = 1'b0;
      cur_cnt    = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + COUNT_WIDTH'(spike_out[i]);
         if (cnt_inc[i] >= stop_count_q) thresh_hit = 1'b1;
         if (wr_idx_q == OUT_ADDR_BITS'(i)) cur_cnt = cnt_q[i];
      end
      run_max = max_q;
      run_idx = max_idx_q;
      if (wr_idx_q == '0 || cur_cnt > max_q) begin
         run_max = cur_cnt;
         run_idx = wr_idx_q;
      end
      phase_wrap = (phase_q == period_q - 1'b1);
      run_last   = phase_wrap && (timestep_q == sim_time_q - 1'b1);
   end

   always_comb begin
      state_d         = state_q;
      sim_time_d      = sim_time_q;
      num_samples_d   = num_samples_q;
      period_d        = period_q;
      thresh_mode_d   = thresh_mode_q;
      stop_count_d    = stop_count_q;
      timestep_d      = timestep_q;
      phase_d         = phase_q;
      sample_idx_d    = sample_idx_q;
      wr_idx_d        = wr_idx_q;
      cnt_d           = cnt_q;
      max_d           = max_q;
      max_idx_d       = max_idx_q;
      winner_d        = winner_q;
      winner_count_d  = winner_count_q;
      stop_timestep_d = stop_timestep_q;
      aborted_d       = aborted_q;
      if (abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         aborted_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               sim_time_d    = cfg_sim_time;
               num_samples_d = (cfg_num_samples == '0) ? SAMPLE_BITS'(1) : cfg_num_samples;
               period_d      = (cfg_spike_period == '0) ? PERIOD_BITS'(1) : cfg_spike_period;
               thresh_mode_d = (cfg_mode == 2'd1);
               stop_count_d  = cfg_stop_count;
               sample_idx_d  = '0;
               aborted_d     = 1'b0;
               state_d       = S_NET_RST;
            end
            S_NET_RST: begin
               for (int i = 0; i < NUM_OUTPUTS; i++) cnt_d[i] = '0;
               timestep_d = '0;
               phase_d    = '0;
               wr_idx_d   = '0;
               if (sim_time_q == '0) begin
                  stop_timestep_d = '0;
                  state_d         = S_WRITE;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               cnt_d      = cnt_inc;
               phase_d    = phase_wrap ? '0 : phase_q + 1'b1;
               timestep_d = phase_wrap ? timestep_q + 1'b1 : timestep_q;
               // A partially executed timestep still counts as one.
               if (run_last || (thresh_mode_q && thresh_hit)) begin
                  stop_timestep_d = timestep_q + 1'b1;
                  state_d         = S_WRITE;
               end
            end
            S_WRITE: begin
               max_d     = run_max;
               max_idx_d = run_idx;
               wr_idx_d  = wr_idx_q + 1'b1;
               if (wr_idx_q == OUT_ADDR_BITS'(NUM_OUTPUTS - 1)) begin
                  winner_d       = run_idx;
                  winner_count_d = run_max;
                  state_d        = S_SAMPLE_END;
               end
            end
            S_SAMPLE_END: begin
               sample_idx_d = sample_idx_q + 1'b1;
               if ({1'b0, sample_idx_q} + 1'b1 < {1'b0, num_samples_q}) state_d = S_NET_RST;
               else state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         sim_time_q      <= '0;
         num_samples_q   <= '0;
         period_q        <= '0;
         thresh_mode_q   <= 1'b0;
         stop_count_q    <= '0;
         timestep_q      <= '0;
         phase_q         <= '0;
         sample_idx_q    <= '0;
         wr_idx_q        <= '0;
         for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
         max_q           <= '0;
         max_idx_q       <= '0;
         winner_q        <= '0;
         winner_count_q  <= '0;
         stop_timestep_q <= '0;
         aborted_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         sim_time_q      <= sim_time_d;
         num_samples_q   <= num_samples_d;
         period_q        <= period_d;
         thresh_mode_q   <= thresh_mode_d;
         stop_count_q    <= stop_count_d;
         timestep_q      <= timestep_d;
         phase_q         <= phase_d;
         sample_idx_q    <= sample_idx_d;
         wr_idx_q        <= wr_idx_d;
         cnt_q           <= cnt_d;
         max_q           <= max_d;
         max_idx_q       <= max_idx_d;
         winner_q        <= winner_d;
         winner_count_q  <= winner_count_d;
         stop_timestep_q <= stop_timestep_d;
         aborted_q       <= aborted_d;
      end
   end

   assign network_rst   = (state_q == S_NET_RST);
   assign spike_en      = (state_q == S_RUN) && (phase_q == '0);
   assign timestep      = timestep_q;
   assign sample_idx    = sample_idx_q;
   assign res_wen       = (state_q == S_WRITE);
   assign res_addr      = {sample_idx_q, wr_idx_q};
   assign res_data      = cur_cnt;
   assign winner        = winner_q;
   assign winner_count  = winner_count_q;
   assign winner_valid  = (state_q == S_SAMPLE_END);
   assign stop_timestep = stop_timestep_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign aborted       = aborted_q;
endmodule

// File: tb/tb_snn_run_sequencer.sv
// Bench for snn_run_sequencer: a per-sample reference model predicts counts, winners and the cycle timeline.
module tb_snn_run_sequencer;
   localparam int N = 4, OAB = 2, CW = 4, TSB = 8, SB = 4, PB = 4;
   localparam int MAXRUN = 128;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic [TSB-1:0] cfg_sim_time = '0;
   logic [SB-1:0]  cfg_num_samples = '0;
   logic [PB-1:0]  cfg_spike_period = '0;
   logic [1:0]     cfg_mode = '0;
   logic [CW-1:0]  cfg_stop_count = '0;
   logic [N-1:0]   spike_out = '0;
   logic network_rst, spike_en, res_wen, winner_valid, busy, done, aborted;
   logic [TSB-1:0] timestep, stop_timestep;
   logic [SB-1:0]  sample_idx;
   logic [SB+OAB-1:0] res_addr;
   logic [CW-1:0]  res_data, winner_count;
   logic [OAB-1:0] winner;

   always #5 clk = ~clk;

   snn_run_sequencer #(.NUM_OUTPUTS(N), .OUT_ADDR_BITS(OAB), .COUNT_WIDTH(CW),
                       .TIMESTEP_BITS(TSB), .SAMPLE_BITS(SB), .PERIOD_BITS(PB)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_sim_time(cfg_sim_time), .cfg_num_samples(cfg_num_samples),
      .cfg_spike_period(cfg_spike_period), .cfg_mode(cfg_mode), .cfg_stop_count(cfg_stop_count),
      .spike_out(spike_out), .network_rst(network_rst), .spike_en(spike_en), .timestep(timestep),
      .sample_idx(sample_idx), .res_wen(res_wen), .res_addr(res_addr), .res_data(res_data),
      .winner(winner), .winner_count(winner_count), .winner_valid(winner_valid),
      .stop_timestep(stop_timestep), .busy(busy), .done(done), .aborted(aborted));

   int checks = 0, failures = 0, cyc = 0;
   int c_t, c_s, c_p, c_mode, c_stop;
   logic [N-1:0] spk [16][MAXRUN];
   int exp_len [16], exp_stop [16], exp_win [16], exp_wcnt [16];
   int exp_cnt [16][N];

   task automatic step();
      @(posedge clk); #1; cyc++;
   endtask

   task automatic noise(input bit with_start);
      if (with_start) start = 1'($urandom);
      cfg_sim_time = TSB'($urandom); cfg_num_samples = SB'($urandom);
      cfg_spike_period = PB'($urandom); cfg_mode = 2'($urandom);
      cfg_stop_count = CW'($urandom); spike_out = N'($urandom);
   endtask

   // Reference: replay each sample's RUN spikes with saturation and the early-stop rule.
   task automatic model();
      int s_eff, p_eff, cmax, len, w;
      int c [N];
      bit hit;
      s_eff = (c_s == 0) ? 1 : c_s;
      p_eff = (c_p == 0) ? 1 : c_p;
      cmax  = (1 << CW) - 1;
      for (int s = 0; s < s_eff; s++) begin
         for (int i = 0; i < N; i++) c[i] = 0;
         len = c_t * p_eff;
         for (int k = 0; k < c_t * p_eff; k++) begin
            for (int i = 0; i < N; i++) if (spk[s][k][i] && c[i] < cmax) c[i]++;
            hit = 0;
            for (int i = 0; i < N; i++) if (c[i] >= c_stop) hit = 1;
            if (c_mode == 1 && hit) begin
               len = k + 1;
               break;
            end
         end
         w = 0;
         for (int i = 1; i < N; i++) if (c[i] > c[w]) w = i;
         exp_len[s]  = len;
         exp_stop[s] = (len + p_eff - 1) / p_eff;
         exp_win[s]  = w;
         exp_wcnt[s] = c[w];
         for (int i = 0; i < N; i++) exp_cnt[s][i] = c[i];
      end
   endtask

   task automatic run_and_check(input string tag);
      int s_eff, p_eff;
      logic [5:0] ctl, e;
      model();
      s_eff = (c_s == 0) ? 1 : c_s;
      p_eff = (c_p == 0) ? 1 : c_p;
      cfg_sim_time = TSB'(c_t); cfg_num_samples = SB'(c_s); cfg_spike_period = PB'(c_p);
      cfg_mode = 2'(c_mode); cfg_stop_count = CW'(c_stop); spike_out = N'($urandom);
      start = 1'b1;
      step();
      for (int s = 0; s < s_eff; s++) begin
         ctl = {busy, network_rst, spike_en, res_wen, winner_valid, done};
         checks++;
         if (ctl !== 6'b110000) begin
            failures++; $display("FAIL %s net_rst ctl cyc=%0d got=%b exp=110000", tag, cyc, ctl);
         end
         noise(1); step();
         for (int k = 0; k < exp_len[s]; k++) begin
            ctl = {busy, network_rst, spike_en, res_wen, winner_valid, done};
            e = {2'b10, (k % p_eff) == 0, 3'b000};
            checks++;
            if (ctl !== e || timestep !== TSB'(k / p_eff) || sample_idx !== SB'(s)) begin
               failures++;
               $display("FAIL %s run s=%0d k=%0d got ctl=%b ts=%0d si=%0d exp ctl=%b ts=%0d si=%0d",
                        tag, s, k, ctl, timestep, sample_idx, e, k / p_eff, s);
            end
            noise(1); spike_out = spk[s][k]; step();
         end
         for (int i = 0; i < N; i++) begin
            ctl = {busy, network_rst, spike_en, res_wen, winner_valid, done};
            checks++;
            if (ctl !== 6'b100100 || res_addr !== (SB+OAB)'((s << OAB) | i) || res_data !== CW'(exp_cnt[s][i])) begin
               failures++;
               $display("FAIL %s write s=%0d i=%0d got ctl=%b addr=%0d data=%0d exp ctl=100100 addr=%0d data=%0d",
                        tag, s, i, ctl, res_addr, res_data, (s << OAB) | i, exp_cnt[s][i]);
            end
            noise(1); step();
         end
         ctl = {busy, network_rst, spike_en, res_wen, winner_valid, done};
         checks++;
         if (ctl !== 6'b100010 || winner !== OAB'(exp_win[s]) || winner_count !== CW'(exp_wcnt[s])
             || stop_timestep !== TSB'(exp_stop[s])) begin
            failures++;
            $display("FAIL %s sample_end s=%0d got ctl=%b win=%0d cnt=%0d stop=%0d exp ctl=100010 win=%0d cnt=%0d stop=%0d",
                     tag, s, ctl, winner, winner_count, stop_timestep, exp_win[s], exp_wcnt[s], exp_stop[s]);
         end
         noise(1); step();
      end
      ctl = {busy, network_rst, spike_en, res_wen, winner_valid, done};
      checks++;
      if (ctl !== 6'b100001 || sample_idx !== SB'(s_eff)) begin
         failures++; $display("FAIL %s done got ctl=%b si=%0d exp ctl=100001 si=%0d", tag, ctl, sample_idx, s_eff);
      end
      noise(1); step();
      start = 1'b0;
      ctl = {busy, network_rst, spike_en, res_wen, winner_valid, done};
      checks++;
      if (ctl !== 6'b000000 || aborted !== 1'b0) begin
         failures++; $display("FAIL %s idle got ctl=%b aborted=%b exp ctl=000000 aborted=0", tag, ctl, aborted);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({network_rst, spike_en, timestep, sample_idx, res_wen, res_addr, res_data, winner, winner_count,
           winner_valid, stop_timestep, busy, done, aborted} !== '0) begin
         failures++;
         $display("FAIL %s outputs not zero busy=%b net_rst=%b ts=%0d si=%0d win=%0d wcnt=%0d aborted=%b",
                  tag, busy, network_rst, timestep, sample_idx, winner, winner_count, aborted);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; step(); step();
      check_all_zero("reset");
      rst = 1'b0; step();
   endtask

   task automatic test_basic();
      c_t = 4; c_s = 1; c_p = 2; c_mode = 0; c_stop = 0;
      for (int k = 0; k < MAXRUN; k++) spk[0][k] = 4'b0001;
      run_and_check("basic");
   endtask

   task automatic test_zero_time();
      c_t = 0; c_s = 1; c_p = 3; c_mode = 0; c_stop = 0;
      run_and_check("zero_time");
   endtask

   task automatic test_threshold();
      c_t = 100; c_s = 1; c_p = 1; c_mode = 1; c_stop = 3;
      for (int k = 0; k < MAXRUN; k++) spk[0][k] = 4'b0100;
      run_and_check("threshold");
   endtask

   task automatic test_multi_sample();
      int dom [3] = '{3, 1, 2};
      c_t = 5; c_s = 3; c_p = 2; c_mode = 0; c_stop = 0;
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < MAXRUN; k++)
            spk[s][k] = N'(1 << dom[s]) | (($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0));
      run_and_check("multi_sample");
   endtask

   task automatic test_saturation();
      c_t = 20; c_s = 1; c_p = 1; c_mode = 0; c_stop = 0;
      for (int k = 0; k < MAXRUN; k++) spk[0][k] = 4'b0011;
      run_and_check("saturation_tie");
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         c_t = $urandom_range(0, 12); c_s = $urandom_range(0, 3); c_p = $urandom_range(0, 4);
         c_mode = $urandom_range(0, 3); c_stop = $urandom_range(0, 15);
         for (int s = 0; s < 16; s++)
            for (int k = 0; k < MAXRUN; k++) spk[s][k] = N'($urandom) & N'($urandom);
         run_and_check("random");
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   task automatic test_abort();
      cfg_sim_time = 8'd2; cfg_num_samples = 4'd1; cfg_spike_period = 4'd1; cfg_mode = 2'd0;
      start = 1'b1; step(); start = 1'b0;
      repeat (4) begin noise(0); step(); end
      checks++;
      if (res_wen !== 1'b1 || res_addr !== 6'd1) begin
         failures++; $display("FAIL abort second_write got wen=%b addr=%0d exp wen=1 addr=1", res_wen, res_addr);
      end
      abort = 1'b1; step(); abort = 1'b0;
      checks++;
      if ({busy, res_wen, done, aborted} !== 4'b0001) begin
         failures++; $display("FAIL abort idle got busy/wen/done/aborted=%b exp 0001", {busy, res_wen, done, aborted});
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || winner_valid !== 1'b0) begin
            failures++; $display("FAIL abort quiet cyc=%0d got done=%b busy=%b wv=%b exp 0", cyc, done, busy, winner_valid);
         end
         noise(0); step();
      end
      start = 1'b1; step(); start = 1'b0;
      checks++;
      if ({aborted, busy, network_rst} !== 3'b011) begin
         failures++; $display("FAIL abort restart got aborted/busy/net_rst=%b exp 011", {aborted, busy, network_rst});
      end
      abort = 1'b1; step(); abort = 1'b0;
      checks++;
      if ({aborted, busy, network_rst} !== 3'b100) begin
         failures++; $display("FAIL abort in_net_rst got aborted/busy/net_rst=%b exp 100", {aborted, busy, network_rst});
      end
   endtask

   task automatic test_reset_mid_run();
      cfg_sim_time = 8'd10; cfg_num_samples = 4'd2; cfg_spike_period = 4'd2; cfg_mode = 2'd0;
      start = 1'b1; step(); start = 1'b0;
      repeat (6) begin noise(0); step(); end
      rst = 1'b1; step(); rst = 1'b0;
      check_all_zero("reset_mid_run");
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_time();
      test_threshold();
      test_multi_sample();
      test_saturation();
      test_abort();
      test_random();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
